// File: rtl/noise_lfsr_multi.sv
// Multi-channel noise source: one shared XNOR-feedback LFSR, NUM_CH channels with a
// per-channel mode and tick prescaler.
// Optional macro NOISE_LFSR_LOCKUP_RECOVER_EN: when defined, a running tick on the
// all-ones lockup state clears the LFSR instead of holding it.
module noise_lfsr_multi #(
  parameter int unsigned LFSR_W = 16,
  parameter int unsigned TAP_A  = 3,
  parameter int unsigned TAP_B  = 14,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DIV_W  = 4,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_en,
  input  logic              run,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [1:0]        wr_mode,
  input  logic [DIV_W-1:0]  wr_div,
  input  logic              seed_we,
  input  logic [LFSR_W-1:0] seed_data,
  output logic [LFSR_W-1:0] lfsr_q,
  output logic [NUM_CH-1:0] noise_out,
  output logic              lockup
);

  localparam logic [1:0] ModeMsbToggle  = 2'd0;
  localparam logic [1:0] ModeNibToggle  = 2'd1;
  localparam logic [1:0] ModeMsbDirect  = 2'd2;
  localparam logic [1:0] ModeMute       = 2'd3;

  logic [LFSR_W-1:0] lfsr_d;
  logic              fb;

  logic [1:0]       mode_q [NUM_CH];
  logic [1:0]       mode_d [NUM_CH];
  logic [DIV_W-1:0] div_q  [NUM_CH];
  logic [DIV_W-1:0] div_d  [NUM_CH];
  logic [DIV_W-1:0] cnt_q  [NUM_CH];
  logic [DIV_W-1:0] cnt_d  [NUM_CH];
  logic [NUM_CH-1:0] noise_q;
  logic [NUM_CH-1:0] noise_d;

  // Shared LFSR next state: seed load beats tick; a stopped tick clears the register.
  always_comb begin
    fb     = ~(lfsr_q[TAP_A] ^ lfsr_q[TAP_B]);
    lfsr_d = lfsr_q;
    if (seed_we) begin
      lfsr_d = seed_data;
    end else if (tick_en) begin
      if (!run) begin
        lfsr_d = '0;
`ifdef NOISE_LFSR_LOCKUP_RECOVER_EN
      end else if (&lfsr_q) begin
        // All-ones maps to itself under XNOR feedback; kick it back to zero.
        lfsr_d = '0;
`endif
      end else begin
        lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
      end
    end
  end

  // Per-channel config, prescaler and output bit. Fire decisions use the
  // pre-update LFSR, so channels still see the old value on a run=0 clear.
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      mode_d[i]  = mode_q[i];
      div_d[i]   = div_q[i];
      cnt_d[i]   = cnt_q[i];
      noise_d[i] = noise_q[i];
      if (wr_en && (wr_ch == CH_W'(i))) begin
        // Config write wins over a same-cycle tick for this channel only.
        mode_d[i]  = wr_mode;
        div_d[i]   = wr_div;
        cnt_d[i]   = '0;
        noise_d[i] = 1'b0;
      end else if (tick_en) begin
        if (cnt_q[i] == div_q[i]) begin
          cnt_d[i] = '0;
          unique case (mode_q[i])
            ModeMsbToggle: noise_d[i] = noise_q[i] ^ lfsr_q[LFSR_W-1];
            ModeNibToggle: noise_d[i] = noise_q[i] ^ ~(&lfsr_q[LFSR_W-2:LFSR_W-5]);
            ModeMsbDirect: noise_d[i] = lfsr_q[LFSR_W-1];
            ModeMute:      noise_d[i] = 1'b0;
            default:       noise_d[i] = noise_q[i];
          endcase
        end else begin
          cnt_d[i] = cnt_q[i] + DIV_W'(1);
        end
      end
    end
  end

  // State registers; reset gives odd channels mode 1 and even channels mode 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q  <= '0;
      noise_q <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        mode_q[i] <= (i % 2 == 1) ? ModeNibToggle : ModeMsbToggle;
        div_q[i]  <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      lfsr_q  <= lfsr_d;
      noise_q <= noise_d;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        mode_q[i] <= mode_d[i];
        div_q[i]  <= div_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  assign noise_out = noise_q;
  assign lockup    = &lfsr_q;

endmodule

// File: tb/tb_noise_lfsr_multi.sv
// Bench for noise_lfsr_multi (3 channels so an out-of-range wr_ch is expressible).
module tb_noise_lfsr_multi;

  localparam int NCH = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_en = 1'b0;
  logic        run = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_ch = '0;
  logic [1:0]  wr_mode = '0;
  logic [3:0]  wr_div = '0;
  logic        seed_we = 1'b0;
  logic [15:0] seed_data = '0;
  logic [15:0] lfsr_q;
  logic [2:0]  noise_out;
  logic        lockup;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state: ticks counted since the last clear of each channel.
  logic [15:0] m_lfsr;
  logic [2:0]  m_noise;
  int          m_mode [NCH];
  int          m_div  [NCH];
  int          m_tcnt [NCH];

  noise_lfsr_multi #(
    .LFSR_W(16), .TAP_A(3), .TAP_B(14), .NUM_CH(NCH), .DIV_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .run(run), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_mode(wr_mode), .wr_div(wr_div), .seed_we(seed_we),
    .seed_data(seed_data), .lfsr_q(lfsr_q), .noise_out(noise_out), .lockup(lockup)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lfsr  = '0;
    m_noise = '0;
    for (int c = 0; c < NCH; c++) begin
      m_mode[c] = c % 2;
      m_div[c]  = 0;
      m_tcnt[c] = 0;
    end
  endtask

  task automatic model_clock(input logic t, input logic r, input logic we,
                             input logic [1:0] ch, input logic [1:0] md,
                             input logic [3:0] dv, input logic sw,
                             input logic [15:0] sd);
    logic [15:0] old;
    int fb;
    old = m_lfsr;
    for (int c = 0; c < NCH; c++) begin
      if (we && int'(ch) == c) begin
        m_mode[c] = int'(md);
        m_div[c]  = int'(dv);
        m_tcnt[c] = 0;
        m_noise[c] = 1'b0;
      end else if (t) begin
        m_tcnt[c]++;
        if (m_tcnt[c] % (m_div[c] + 1) == 0) begin
          case (m_mode[c])
            0: if (old[15]) m_noise[c] = ~m_noise[c];
            1: if (((old >> 11) & 16'hF) != 16'hF) m_noise[c] = ~m_noise[c];
            2: m_noise[c] = old[15];
            default: m_noise[c] = 1'b0;
          endcase
        end
      end
    end
    if (sw) begin
      m_lfsr = sd;
    end else if (t) begin
      if (!r) begin
        m_lfsr = 16'h0000;
`ifdef NOISE_LFSR_LOCKUP_RECOVER_EN
      end else if (old == 16'hFFFF) begin
        m_lfsr = 16'h0000;
`endif
      end else begin
        fb = (((old >> 3) & 1) == ((old >> 14) & 1)) ? 1 : 0;
        m_lfsr = 16'((int'(old) * 2 + fb) % 65536);
      end
    end
  endtask

  task automatic check_all();
    chk("lfsr", 32'(lfsr_q), 32'(m_lfsr));
    chk("noise", 32'(noise_out), 32'(m_noise));
    chk("lockup", 32'(lockup), 32'(m_lfsr == 16'hFFFF));
  endtask

  // One clock with the given inputs, then compare against the model.
  task automatic step(input logic t, input logic r, input logic we, input logic [1:0] ch,
                      input logic [1:0] md, input logic [3:0] dv, input logic sw,
                      input logic [15:0] sd);
    tick_en = t; run = r; wr_en = we; wr_ch = ch; wr_mode = md; wr_div = dv;
    seed_we = sw; seed_data = sd;
    model_clock(t, r, we, ch, md, dv, sw, sd);
    @(posedge clk);
    #1;
    tick_en = 1'b0; wr_en = 1'b0; seed_we = 1'b0;
    check_all();
  endtask

  logic [15:0] exp_seq [5];
  logic [2:0]  ch1_before;

  initial begin
    exp_seq[0] = 16'h0001; exp_seq[1] = 16'h0003; exp_seq[2] = 16'h0007;
    exp_seq[3] = 16'h000F; exp_seq[4] = 16'h001E;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Free-running sequence from reset.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 16'h0);
      chk("seq_lfsr", 32'(lfsr_q), 32'(exp_seq[k]));
      chk("seq_ch0", 32'(noise_out[0]), 32'd0);
    end

    // Seed MSB, ch0 mode 0 div 0: one tick toggles ch0.
    step(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 4'd0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b1, 16'h8000);
    step(1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 16'h0);
    chk("seed_tick_lfsr", 32'(lfsr_q), 32'h0001);
    chk("seed_tick_ch0", 32'(noise_out[0]), 32'd1);

    // ch1 divide-by-4 after a write, continuous ticks.
    step(1'b0, 1'b1, 1'b1, 2'd1, 2'd0, 4'd3, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b1, 16'hFFFE);
    for (int k = 1; k <= 8; k++) begin
      ch1_before = noise_out;
      step(1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 16'h0);
      if (k % 4 != 0) chk("div_hold_ch1", 32'(noise_out[1]), 32'(ch1_before[1]));
    end

    // Stopped tick clears LFSR; channels act on the old value.
    step(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 16'h0);
    chk("run0_clear", 32'(lfsr_q), 32'h0000);

    // Same-cycle write to ch0 and tick.
    step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b1, 16'hA5C3);
    step(1'b1, 1'b1, 1'b1, 2'd0, 2'd2, 4'd1, 1'b0, 16'h0);
    chk("wr_tick_ch0", 32'(noise_out[0]), 32'd0);

    // Out-of-range channel write is ignored (model ignores ch 3 too).
    step(1'b0, 1'b1, 1'b1, 2'd3, 2'd3, 4'd5, 1'b0, 16'h0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 16'h0);

    // Lockup state.
    step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b1, 16'hFFFF);
    chk("lockup_seeded", 32'(lockup), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 16'h0);
`ifdef NOISE_LFSR_LOCKUP_RECOVER_EN
      if (k == 0) chk("lockup_recover", 32'(lfsr_q), 32'h0000);
`else
      chk("lockup_hold", 32'(lfsr_q), 32'hFFFF);
      chk("lockup_flag", 32'(lockup), 32'd1);
`endif
    end

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(1, 0)), ($urandom_range(9, 0) != 0),
           ($urandom_range(9, 0) == 0), 2'($urandom_range(3, 0)),
           2'($urandom_range(3, 0)), 4'($urandom_range(15, 0)),
           ($urandom_range(19, 0) == 0), 16'($urandom));
    end

    // Asynchronous reset mid-cycle takes effect before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
